bus_demux3: RTL and testbench

- Single-initiator to three-target data-bus router for the SoC memory path.
- Accepts one CPU load/store request at a time and decodes the address into one of three regions.
- Forwards the request to the matching target as a one-hot request, then waits for that target's acknowledge.
- Returns the selected target's read data, or reports an error for unmapped addresses and timeouts.

---
 rtl/bus_demux3.sv | 182 ++++++++++++++++++
 tb/tb_bus_demux3.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_demux3.sv
// Routes one initiator load/store to one of three address-decoded targets and returns data or error.
// Latency: mapped access acks one cycle after the target ack (or after TIMEOUT request cycles); unmapped acks in cycle 1.
// Backpressure: a single transaction in flight; I_req while O_busy is high is dropped, not queued.
module bus_demux3 #(
  parameter logic [31:0] REGION1_BASE = 32'h00000000,
  parameter logic [31:0] REGION2_BASE = 32'h10000000,
  parameter logic [31:0] REGION3_BASE = 32'h20000000,
  parameter logic [31:0] REGION_MASK  = 32'hF0000000,
  parameter int          TIMEOUT      = 16
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_req,
  input  logic        I_we,
  input  logic [31:0] I_addr,
  input  logic [31:0] I_wdata,
  input  logic [3:0]  I_be,
  output logic        O_busy,
  output logic        O_ack,
  output logic        O_err,
  output logic [31:0] O_rdata,
  output logic [2:0]  O_req,
  output logic        O_we,
  output logic [31:0] O_addr,
  output logic [31:0] O_wdata,
  output logic [3:0]  O_be,
  input  logic [2:0]  I_ack,
  input  logic [31:0] I_rdata1,
  input  logic [31:0] I_rdata2,
  input  logic [31:0] I_rdata3
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  // Last counter value allowed in ACCESS before the access is abandoned.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  sel_q, sel_d;
  logic        busy_q, busy_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;

  logic [2:0]  hit;
  logic [31:0] sel_rdata;

  // Decode the incoming address; lowest-numbered matching region wins.
  always_comb begin
    hit = 3'b000;
    if ((I_addr & REGION_MASK) == REGION1_BASE)      hit = 3'b001;
    else if ((I_addr & REGION_MASK) == REGION2_BASE) hit = 3'b010;
    else if ((I_addr & REGION_MASK) == REGION3_BASE) hit = 3'b100;
  end

  // Pick the read data of the latched target.
  always_comb begin
    sel_rdata = 32'h0;
    case (sel_q)
      3'b001:  sel_rdata = I_rdata1;
      3'b010:  sel_rdata = I_rdata2;
      3'b100:  sel_rdata = I_rdata3;
      default: sel_rdata = 32'h0;
    endcase
  end

  // Next-state and next-output logic; everything holds unless a state acts on it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    ack_d   = ack_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      S_IDLE: begin
        if (I_req) begin
          we_d    = I_we;
          addr_d  = I_addr;
          wdata_d = I_wdata;
          be_d    = I_be;
          sel_d   = hit;
          if (hit != 3'b000) begin
            state_d = S_ACCESS;
            req_d   = hit;
            cnt_d   = 16'd0;
          end else begin
            state_d = S_DONE;
            req_d   = 3'b000;
            ack_d   = 1'b1;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + 16'd1;
        // Only the selected target's ack counts; ack beats a same-cycle timeout.
        if ((I_ack & sel_q) != 3'b000) begin
          state_d = S_DONE;
          req_d   = 3'b000;
          ack_d   = 1'b1;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : sel_rdata;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_DONE;
          req_d   = 3'b000;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = 32'h0;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 3'b000;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = 32'h0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs, synchronously cleared by reset.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      sel_q   <= 3'b000;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      req_q   <= 3'b000;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  assign O_busy  = busy_q;
  assign O_ack   = ack_q;
  assign O_err   = err_q;
  assign O_rdata = rdata_q;
  assign O_req   = req_q;
  assign O_we    = we_q;
  assign O_addr  = addr_q;
  assign O_wdata = wdata_q;
  assign O_be    = be_q;

endmodule

// File: tb/tb_bus_demux3.sv
// Scoreboard bench for bus_demux3: driver pushes expected completions, monitor pops on O_ack.
// Latency: driver steps one transaction at a time and waits (bounded) for O_busy to drop.
// Backpressure: random I_req pulses are injected while busy and must have no effect.
module tb_bus_demux3;

  localparam int TIMEOUT = 16;

  logic        I_clk = 1'b0;
  logic        I_rst = 1'b1;
  logic        I_req = 1'b0;
  logic        I_we = 1'b0;
  logic [31:0] I_addr = 32'h0;
  logic [31:0] I_wdata = 32'h0;
  logic [3:0]  I_be = 4'h0;
  logic [2:0]  I_ack = 3'b000;
  logic [31:0] I_rdata1 = 32'h0;
  logic [31:0] I_rdata2 = 32'h0;
  logic [31:0] I_rdata3 = 32'h0;
  logic        O_busy, O_ack, O_err, O_we;
  logic [31:0] O_rdata, O_addr, O_wdata;
  logic [2:0]  O_req;
  logic [3:0]  O_be;

  bus_demux3 #(.TIMEOUT(TIMEOUT)) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_req(I_req), .I_we(I_we), .I_addr(I_addr),
    .I_wdata(I_wdata), .I_be(I_be), .O_busy(O_busy), .O_ack(O_ack), .O_err(O_err),
    .O_rdata(O_rdata), .O_req(O_req), .O_we(O_we), .O_addr(O_addr), .O_wdata(O_wdata),
    .O_be(O_be), .I_ack(I_ack), .I_rdata1(I_rdata1), .I_rdata2(I_rdata2), .I_rdata3(I_rdata3)
  );

  always #5 I_clk = ~I_clk;

  typedef struct {
    logic [2:0]  req;
    int          ncyc;
    logic        err;
    logic [31:0] rdata;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   reqcnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode: top address nibble 0/1/2 selects target 1/2/3, anything else is unmapped.
  function automatic int addr_target(input logic [31:0] a);
    int nib;
    nib = int'(a / 32'h10000000);
    return (nib < 3) ? nib + 1 : 0;
  endfunction

  // Monitor: checks the target request vector while it is up and each completion against the queue.
  always @(negedge I_clk) begin
    exp_t e;
    if (I_rst) begin
      reqcnt = 0;
    end else begin
      if (O_req != 3'b000) begin
        reqcnt++;
        if (q.size() > 0) chk("req_vec", 32'(O_req), 32'(q[0].req));
      end
      if (O_ack) begin
        if (q.size() == 0) begin
          chk("unexpected_ack", 32'(O_ack), 32'h0);
        end else begin
          e = q.pop_front();
          chk("err", 32'(O_err), 32'(e.err));
          chk("rdata", O_rdata, e.rdata);
          chk("req_cycles", 32'(reqcnt), 32'(e.ncyc));
          chk("we", 32'(O_we), 32'(e.we));
          chk("addr", O_addr, e.addr);
          chk("wdata", O_wdata, e.wdata);
          chk("be", 32'(O_be), 32'(e.be));
        end
        reqcnt = 0;
      end
    end
  end

  // One transaction: target acks in request cycle d (0 = never); pulse_mask hits non-selected acks in cycle pulse_cyc.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int d, input logic [2:0] pulse_mask,
                         input int pulse_cyc, input bit busy_req);
    exp_t        e;
    int          tgt;
    logic [2:0]  oh;
    logic [31:0] rd [3];
    bit          done;
    rd[0] = $urandom; rd[1] = $urandom; rd[2] = $urandom;
    I_rdata1 = rd[0]; I_rdata2 = rd[1]; I_rdata3 = rd[2];
    tgt = addr_target(addr);
    oh  = (tgt == 0) ? 3'b000 : 3'(1 << (tgt - 1));
    e.req = oh; e.we = we; e.addr = addr; e.wdata = wdata; e.be = be;
    if (tgt == 0) begin
      e.ncyc = 0; e.err = 1'b1; e.rdata = 32'h0;
    end else if (d >= 1 && d <= TIMEOUT) begin
      e.ncyc = d; e.err = 1'b0; e.rdata = we ? 32'h0 : rd[tgt-1];
    end else begin
      e.ncyc = TIMEOUT; e.err = 1'b1; e.rdata = 32'h0;
    end
    q.push_back(e);
    I_req = 1'b1; I_we = we; I_addr = addr; I_wdata = wdata; I_be = be;
    @(posedge I_clk); #1;
    I_req = 1'b0;
    chk("busy_after_accept", 32'(O_busy), 32'h1);
    done = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      I_ack = ((tgt != 0 && c == d) ? oh : 3'b000) | ((c == pulse_cyc) ? (pulse_mask & ~oh) : 3'b000);
      I_req = busy_req ? 1'($urandom_range(0, 1)) : 1'b0;
      if (I_req) begin
        I_addr = $urandom; I_we = 1'($urandom); I_wdata = $urandom; I_be = 4'($urandom);
      end
      @(posedge I_clk); #1;
      if (!O_busy) begin
        done = 1'b1;
        break;
      end
    end
    I_ack = 3'b000; I_req = 1'b0;
    chk("busy_drops", 32'(done), 32'h1);
    chk("ack_one_cycle", 32'(O_ack), 32'h0);
    chk("err_cleared", 32'(O_err), 32'h0);
    chk("rdata_cleared", O_rdata, 32'h0);
  endtask

  initial begin
    int region, d;
    logic [3:0]  nib;
    logic [31:0] a;

    repeat (2) @(posedge I_clk);
    #1;
    I_rst = 1'b0;
    chk("rst_req", 32'(O_req), 32'h0);
    chk("rst_ack", 32'(O_ack), 32'h0);
    chk("rst_err", 32'(O_err), 32'h0);
    chk("rst_busy", 32'(O_busy), 32'h0);
    chk("rst_rdata", O_rdata, 32'h0);
    @(posedge I_clk); #1;

    // Read to target 2, acked on third request cycle with a fixed data word.
    run_txn(1'b0, 32'h10000040, 32'h0, 4'hF, 3, 3'b000, 0, 1'b0);
    // Overwrite the randomised value with the directed one by issuing again with a known word.
    I_rdata2 = 32'hDEADBEEF;
    q.push_back('{req: 3'b010, ncyc: 3, err: 1'b0, rdata: 32'hDEADBEEF, we: 1'b0,
                  addr: 32'h10000040, wdata: 32'h0, be: 4'hF});
    I_req = 1'b1; I_we = 1'b0; I_addr = 32'h10000040; I_wdata = 32'h0; I_be = 4'hF;
    @(posedge I_clk); #1;
    I_req = 1'b0;
    repeat (2) begin
      chk("t2_req_held", 32'(O_req), 32'h2);
      @(posedge I_clk); #1;
    end
    I_ack = 3'b010;
    @(posedge I_clk); #1;
    I_ack = 3'b000;
    chk("t2_ack", 32'(O_ack), 32'h1);
    chk("t2_rdata", O_rdata, 32'hDEADBEEF);
    @(posedge I_clk); #1;
    chk("t2_idle", 32'(O_busy), 32'h0);

    // Write to target 1 with immediate ack.
    run_txn(1'b1, 32'h00000100, 32'h12345678, 4'b0011, 1, 3'b000, 0, 1'b0);
    // Unmapped access.
    run_txn(1'b0, 32'h30000000, 32'hA5A5A5A5, 4'hF, 1, 3'b000, 0, 1'b0);
    // Timeout on target 3 with a stray target-1 ack mid-access.
    run_txn(1'b0, 32'h20000010, 32'h0, 4'hF, 0, 3'b001, 5, 1'b0);
    // Ack exactly on the last allowed cycle: ack wins over timeout.
    run_txn(1'b0, 32'h20000020, 32'h0, 4'hF, TIMEOUT, 3'b011, TIMEOUT, 1'b1);

    // Reset in the middle of an access, with a busy-time request and a late ack.
    I_req = 1'b1; I_we = 1'b0; I_addr = 32'h10000000; I_be = 4'hF;
    @(posedge I_clk); #1;
    I_req = 1'b0;
    @(posedge I_clk); #1;
    I_req = 1'b1; I_addr = 32'h00000000;
    @(posedge I_clk); #1;
    I_req = 1'b0;
    chk("busy_req_ignored", 32'(O_req), 32'h2);
    I_rst = 1'b1;
    @(posedge I_clk); #1;
    I_rst = 1'b0;
    chk("midrst_req", 32'(O_req), 32'h0);
    chk("midrst_busy", 32'(O_busy), 32'h0);
    chk("midrst_addr", O_addr, 32'h0);
    I_ack = 3'b010;
    repeat (3) begin
      @(posedge I_clk); #1;
      chk("late_ack_no_ack", 32'(O_ack), 32'h0);
      chk("late_ack_idle", 32'(O_busy), 32'h0);
    end
    I_ack = 3'b000;

    // Randomised traffic.
    for (int i = 0; i < 60; i++) begin
      region = $urandom_range(0, 4);
      nib = (region < 4) ? 4'(region) : 4'($urandom_range(3, 15));
      a = {nib, 28'($urandom)};
      d = $urandom_range(0, 20);
      run_txn(1'($urandom), a, $urandom, 4'($urandom), d, 3'($urandom), $urandom_range(1, 18), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge I_clk); #1;
      end
    end

    repeat (3) @(posedge I_clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
